inst_mem_resp: RTL and testbench

- Instruction-memory responder: the memory end of the fetch read interface driven by inst_fetch.
- inst_fetch drives a read address and read enable, then consumes the low 32 bits of the returned 64-bit word as the instruction.
- This block owns a 64-bit-wide instruction store, accepts read requests, and returns data after a fixed, parameterised wait-state latency.
- A byte-strobed write port loads the program and supports self-modifying tests.
- Sits between the pc/inst_fetch stage and the simulated RAM image.

---
 rtl/inst_mem_pkg.sv | 24 ++
 rtl/inst_mem_array.sv | 44 ++++
 rtl/inst_mem_resp.sv | 153 +++++++++++++++
 tb/tb_inst_mem_resp.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction-memory responder: widths, FSM encoding,
// default base address and the half-word select used on the read path.
package inst_mem_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned STRB_W = WORD_W / 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [63:0] DEF_BASE_ADDR = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Upper instruction of a word is shifted down so the addressed one is always in [31:0]
  function automatic logic [WORD_W-1:0] half_select(input logic [WORD_W-1:0] word,
                                                    input logic              hi);
    return hi ? {{INST_W{1'b0}}, word[WORD_W-1:INST_W]} : word;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// 64-bit wide instruction store: one registered read port and one byte-strobed
// write port; a read and a write to the same word at one edge returns the old data.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] ridx_i,
  output logic [WORD_W-1:0]     rdata_o,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] widx_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_d;
  logic [WORD_W-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem[ridx_i];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we_i) begin
      for (int k = 0; k < int'(STRB_W); k++) begin
        if (wstrb_i[k]) begin
          mem[widx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: accepts fetch reads, decodes/faults the address and
// returns the word after LATENCY cycles; a byte-strobed write port loads the store.
module inst_mem_resp
  import inst_mem_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren_i,
  input  logic [63:0] raddr_i,
  output logic        req_ready_o,
  output logic [63:0] rdata_o,
  output logic        rvalid_o,
  output logic        rerr_o,
  input  logic        we_i,
  input  logic [63:0] waddr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wstrb_i
);

  localparam logic [63:0]      MEM_BYTES = 64'(8) << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_INIT  = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
  localparam state_e           ACC_STATE = (LATENCY == 1) ? RESP : WAIT;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   pend_idx_q, pend_idx_d;
  logic                    pend_hi_q, pend_hi_d;
  logic                    pend_fault_q, pend_fault_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic                    hi_q, hi_d;
  logic                    blank_q, blank_d;

  logic [63:0]             roff_c, woff_c;
  logic                    rd_fault_c, wr_ok_c, accept_c;
  logic [DEPTH_LOG2-1:0]   rd_idx_c, wr_idx_c;
  logic                    arr_re_c;
  logic [DEPTH_LOG2-1:0]   arr_ridx_c;
  logic                    resp_fault_c, resp_hi_c;
  logic [WORD_W-1:0]       arr_rdata;

  // Address decode for both ports
  assign roff_c     = raddr_i - BASE_ADDR;
  assign rd_fault_c = (raddr_i < BASE_ADDR) || (roff_c >= MEM_BYTES) || (raddr_i[1:0] != 2'b00);
  assign rd_idx_c   = roff_c[DEPTH_LOG2+2:3];

  assign woff_c   = waddr_i - BASE_ADDR;
  assign wr_ok_c  = (waddr_i >= BASE_ADDR) && (woff_c < MEM_BYTES);
  assign wr_idx_c = woff_c[DEPTH_LOG2+2:3];

  assign req_ready_o = !rst && (state_q != WAIT);
  assign accept_c    = ren_i && req_ready_o;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_idx_d   = pend_idx_q;
    pend_hi_d    = pend_hi_q;
    pend_fault_d = pend_fault_q;
    rvalid_d     = 1'b0;
    err_d        = err_q;
    hi_d         = hi_q;
    blank_d      = blank_q;
    arr_re_c     = 1'b0;
    arr_ridx_c   = rd_idx_c;
    resp_fault_c = rd_fault_c;
    resp_hi_c    = raddr_i[2];

    unique case (state_q)
      IDLE, RESP: begin
        if (accept_c) begin
          state_d      = ACC_STATE;
          cnt_d        = CNT_INIT;
          pend_idx_d   = rd_idx_c;
          pend_hi_d    = raddr_i[2];
          pend_fault_d = rd_fault_c;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The array is read at the edge entering RESP, from the held request when leaving WAIT
    if (state_q == WAIT) begin
      arr_ridx_c   = pend_idx_q;
      resp_fault_c = pend_fault_q;
      resp_hi_c    = pend_hi_q;
    end

    if (state_d == RESP) begin
      rvalid_d = 1'b1;
      arr_re_c = !resp_fault_c;
      err_d    = resp_fault_c;
      blank_d  = resp_fault_c;
      hi_d     = resp_hi_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_idx_q   <= '0;
      pend_hi_q    <= 1'b0;
      pend_fault_q <= 1'b0;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      hi_q         <= 1'b0;
      blank_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_idx_q   <= pend_idx_d;
      pend_hi_q    <= pend_hi_d;
      pend_fault_q <= pend_fault_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      hi_q         <= hi_d;
      blank_q      <= blank_d;
    end
  end

  inst_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .re_i    (arr_re_c),
    .ridx_i  (arr_ridx_c),
    .rdata_o (arr_rdata),
    .we_i    (we_i && wr_ok_c),
    .widx_i  (wr_idx_c),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i)
  );

  // blank_q forces zero data after reset and on faulted responses
  assign rdata_o  = blank_q ? '0 : half_select(arr_rdata, hi_q);
  assign rvalid_o = rvalid_q;
  assign rerr_o   = err_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three responders (LATENCY 1, 3, 4) share the write port;
// each read pushes its expected response and due cycle, popped when rvalid_o fires.
module tb_inst_mem_resp;

  localparam int NDUT = 3;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;

  logic        ren    [NDUT];
  logic [63:0] raddr  [NDUT];
  logic        ready  [NDUT];
  logic [63:0] rdata  [NDUT];
  logic        rvalid [NDUT];
  logic        rerr   [NDUT];

  exp_t exp_q [NDUT][$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  inst_mem_resp #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .ren_i(ren[0]), .raddr_i(raddr[0]), .req_ready_o(ready[0]),
    .rdata_o(rdata[0]), .rvalid_o(rvalid[0]), .rerr_o(rerr[0]),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb));

  inst_mem_resp #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .ren_i(ren[1]), .raddr_i(raddr[1]), .req_ready_o(ready[1]),
    .rdata_o(rdata[1]), .rvalid_o(rvalid[1]), .rerr_o(rerr[1]),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb));

  inst_mem_resp #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .ren_i(ren[2]), .raddr_i(raddr[2]), .req_ready_o(ready[2]),
    .rdata_o(rdata[2]), .rvalid_o(rvalid[2]), .rerr_o(rerr[2]),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  // Scoreboard: every rvalid pulse must match the oldest expectation, in data and cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (rvalid[d] === 1'b1) begin
        checks++;
        if (exp_q[d].size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid dut%0d cyc=%0d got rvalid=1 want 0", d, cyc);
        end else begin
          e = exp_q[d].pop_front();
          if (cyc !== e.due) begin
            failures++;
            $display("FAIL resp_cycle dut%0d got=%0d exp=%0d", d, cyc, e.due);
          end
          checks++;
          if (rdata[d] !== e.data) begin
            failures++;
            $display("FAIL resp_data dut%0d got=%h exp=%h", d, rdata[d], e.data);
          end
          checks++;
          if (rerr[d] !== e.err) begin
            failures++;
            $display("FAIL resp_err dut%0d got=%b exp=%b", d, rerr[d], e.err);
          end
        end
      end else if (exp_q[d].size() > 0 && exp_q[d][0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_rvalid dut%0d cyc=%0d got rvalid=0 want 1 (due %0d)",
                 d, cyc, exp_q[d][0].due);
        void'(exp_q[d].pop_front());
      end
    end
  end

  // Called at a negedge; the write lands at the following posedge
  task automatic wr(input logic [63:0] a, input logic [63:0] dat, input logic [7:0] s);
    we = 1'b1; waddr = a; wdata = dat; wstrb = s;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge
  task automatic issue(input int d, input logic [63:0] a, input logic [63:0] ed,
                       input logic ee, input bit push);
    bit ok;
    ok = 1'b0;
    ren[d] = 1'b1;
    raddr[d] = a;
    for (int k = 0; k < 32 && !ok; k++) begin
      if (ready[d] === 1'b1) begin
        ok = 1'b1;
        if (push) exp_q[d].push_back('{ed, ee, cyc + lat_of(d)});
      end
      @(negedge clk);
    end
    ren[d] = 1'b0;
    raddr[d] = '0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout dut%0d addr=%h got ready=0 want 1", d, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    for (int d = 0; d < NDUT; d++) begin
      ren[d] = 1'b0;
      raddr[d] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    wr(64'h8000_0000, 64'h0010_0093_0000_0013, 8'hFF);
    wr(64'h8000_0008, 64'h1111_2222_3333_4444, 8'hFF);
    wr(64'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    for (int d = 0; d < NDUT; d++) begin
      checks += 4;
      if (ready[d] !== 1'b0) begin failures++; $display("FAIL rst_ready dut%0d got=%b exp=0", d, ready[d]); end
      if (rvalid[d] !== 1'b0) begin failures++; $display("FAIL rst_rvalid dut%0d got=%b exp=0", d, rvalid[d]); end
      if (rdata[d] !== 64'h0) begin failures++; $display("FAIL rst_rdata dut%0d got=%h exp=0", d, rdata[d]); end
      if (rerr[d] !== 1'b0) begin failures++; $display("FAIL rst_rerr dut%0d got=%b exp=0", d, rerr[d]); end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (ready[d] !== 1'b1) begin failures++; $display("FAIL post_rst_ready dut%0d got=%b exp=1", d, ready[d]); end
    end
    @(negedge clk);
  endtask

  task automatic test_basic_l1();
    issue(0, 64'h8000_0000, 64'h0010_0093_0000_0013, 1'b0, 1'b1);
    issue(0, 64'h8000_0004, 64'h0000_0000_0010_0093, 1'b0, 1'b1);
    issue(0, 64'h8000_000C, 64'h0000_0000_1111_2222, 1'b0, 1'b1);
    issue(0, 64'h8000_7FFC, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b1);
    issue(0, 64'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (rvalid[0] !== 1'b0) begin failures++; $display("FAIL hold_rvalid dut0 got=%b exp=0", rvalid[0]); end
    if (rdata[0] !== 64'hDEAD_BEEF_CAFE_F00D) begin
      failures++; $display("FAIL hold_rdata dut0 got=%h exp=%h", rdata[0], 64'hDEAD_BEEF_CAFE_F00D);
    end
  endtask

  task automatic test_latency_l3();
    issue(1, 64'h8000_0008, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
    checks++;
    if (ready[1] !== 1'b0) begin failures++; $display("FAIL wait_ready_1 dut1 got=%b exp=0", ready[1]); end
    @(negedge clk);
    checks++;
    if (ready[1] !== 1'b0) begin failures++; $display("FAIL wait_ready_2 dut1 got=%b exp=0", ready[1]); end
    @(negedge clk);
    checks++;
    if (ready[1] !== 1'b1) begin failures++; $display("FAIL resp_ready dut1 got=%b exp=1", ready[1]); end
    issue(1, 64'h8000_0000, 64'h0010_0093_0000_0013, 1'b0, 1'b1);
    issue(1, 64'h8000_0004, 64'h0000_0000_0010_0093, 1'b0, 1'b1);
    issue(1, 64'h8000_000C, 64'h0000_0000_1111_2222, 1'b0, 1'b1);
    issue(1, 64'h8000_0006, 64'h0, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_faults();
    issue(0, 64'h7FFF_FFFC, 64'h0, 1'b1, 1'b1);
    issue(0, 64'h8000_8000, 64'h0, 1'b1, 1'b1);
    issue(0, 64'h8000_0002, 64'h0, 1'b1, 1'b1);
    issue(0, 64'h8000_0008, 64'h1111_2222_3333_4444, 1'b0, 1'b1);
    issue(2, 64'h7FFF_FFFC, 64'h0, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_strobes();
    wr(64'h8000_0000, 64'h0, 8'hFF);
    wr(64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    issue(0, 64'h8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    wr(64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF);
    wr(64'h8000_0017, 64'hFFEE_DDCC_BBAA_9988, 8'hA5);
    issue(0, 64'h8000_0010, 64'hFF23_DD67_89AA_CD88, 1'b0, 1'b1);
    issue(0, 64'h8000_0014, 64'h0000_0000_FF23_DD67, 1'b0, 1'b1);
    wr(64'h8000_8000, 64'h5555_5555_5555_5555, 8'hFF);
    wr(64'h7FFF_FFF8, 64'h6666_6666_6666_6666, 8'hFF);
    issue(0, 64'h8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    issue(0, 64'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ordering();
    wr(64'h8000_0018, 64'hAAAA_0000_AAAA_0001, 8'hFF);
    we = 1'b1; waddr = 64'h8000_0018; wdata = 64'hBBBB_0000_BBBB_0002; wstrb = 8'hFF;
    issue(0, 64'h8000_0018, 64'hAAAA_0000_AAAA_0001, 1'b0, 1'b1);
    we = 1'b0;
    issue(0, 64'h8000_0018, 64'hBBBB_0000_BBBB_0002, 1'b0, 1'b1);
    wr(64'h8000_0018, 64'hCCCC_0000_CCCC_0003, 8'hFF);
    issue(0, 64'h8000_0018, 64'hCCCC_0000_CCCC_0003, 1'b0, 1'b1);
    // LATENCY 3: the capture edge is two edges after acceptance
    issue(1, 64'h8000_0018, 64'hCCCC_0000_CCCC_0003, 1'b0, 1'b1);
    @(negedge clk);
    wr(64'h8000_0018, 64'hDDDD_0000_DDDD_0004, 8'hFF);
    issue(1, 64'h8000_0018, 64'hEEEE_0000_EEEE_0005, 1'b0, 1'b1);
    wr(64'h8000_0018, 64'hEEEE_0000_EEEE_0005, 8'hFF);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    issue(2, 64'h8000_0000, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (ready[2] !== 1'b0) begin failures++; $display("FAIL midrst_ready dut2 got=%b exp=0", ready[2]); end
    if (rvalid[2] !== 1'b0) begin failures++; $display("FAIL midrst_rvalid dut2 got=%b exp=0", rvalid[2]); end
    if (rdata[2] !== 64'h0) begin failures++; $display("FAIL midrst_rdata dut2 got=%h exp=0", rdata[2]); end
    rst = 1'b0;
    #1;
    checks++;
    if (ready[2] !== 1'b1) begin failures++; $display("FAIL after_rst_ready dut2 got=%b exp=1", ready[2]); end
    @(negedge clk);
    checks++;
    if (ready[2] !== 1'b1) begin failures++; $display("FAIL idle_ready dut2 got=%b exp=1", ready[2]); end
    repeat (8) @(negedge clk);
    issue(2, 64'h8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
    issue(2, 64'h8000_7FF8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_l1();
    test_latency_l3();
    test_faults();
    test_strobes();
    test_ordering();
    test_reset_mid_wait();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        failures++;
        $display("FAIL drain dut%0d got=%0d pending exp=0", d, exp_q[d].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
